// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } ctrl_state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose rd feeds an ID source.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hazard
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = mem_read && (rd != X0) &&
                  ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: dmem stalls, divide sequencing,
// branch flush, load-use bubble, fetch wait, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exMemRead,
  input  logic                  exBranchTaken,
  input  logic                  exDivStart,
  input  logic                  imemReady,
  input  logic                  dmemReq,
  input  logic                  dmemReady,
  output logic                  pcEn,
  output logic                  ifidEn,
  output logic                  idexEn,
  output logic                  exmemEn,
  output logic                  memwbEn,
  output logic                  ifidFlush,
  output logic                  idexFlush,
  output logic                  exmemFlush,
  output logic                  memwbFlush,
  output logic                  divBusy,
  output logic                  divDone,
  output logic [CNT_W-1:0]      stallCount
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

  ctrl_state_t   state, state_nxt;
  logic [CW-1:0] divCnt, divCnt_nxt;
  logic          load_use;
  logic          dmem_stall;
  // {pc, ifid, idex, exmem, memwb} and {ifid, idex, exmem, memwb}
  logic [4:0]    en;
  logic [3:0]    fl;

  load_use_detect u_lud (
    .rs1      (idRs1),
    .rs2      (idRs2),
    .uses_rs1 (idUsesRs1),
    .uses_rs2 (idUsesRs2),
    .rd       (exRd),
    .mem_read (exMemRead),
    .hazard   (load_use)
  );

  assign dmem_stall = dmemReq && !dmemReady;

  always_comb begin
    en         = 5'b11111;
    fl         = 4'b0000;
    divBusy    = 1'b0;
    divDone    = 1'b0;
    state_nxt  = state;
    divCnt_nxt = divCnt;
    if (rst) begin
      en = 5'b00000;
      fl = 4'b1111;
    end else if (dmem_stall) begin
      en      = 5'b00000;
      divBusy = (state == DIV_WAIT);
    end else if (state == DIV_WAIT && divCnt != '0) begin
      // divide held in EX; MEM gets bubbles while older work drains
      en         = 5'b00011;
      fl         = 4'b0010;
      divBusy    = 1'b1;
      divCnt_nxt = divCnt - CW'(1);
    end else if (state == RUN && exDivStart) begin
      en         = 5'b00011;
      fl         = 4'b0010;
      divBusy    = 1'b1;
      divCnt_nxt = DIV_LOAD;
      state_nxt  = DIV_WAIT;
    end else begin
      if (state == DIV_WAIT) begin
        divDone   = 1'b1;
        divBusy   = 1'b1;
        state_nxt = RUN;
      end
      if (exBranchTaken) begin
        fl = 4'b1100;
      end else if (load_use) begin
        en = 5'b00011;
        fl = 4'b0100;
      end else if (!imemReady) begin
        en = 5'b01111;
        fl = 4'b1000;
      end
    end
  end

  assign {pcEn, ifidEn, idexEn, exmemEn, memwbEn}      = en;
  assign {ifidFlush, idexFlush, exmemFlush, memwbFlush} = fl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      divCnt     <= '0;
      stallCount <= '0;
    end else begin
      state  <= state_nxt;
      divCnt <= divCnt_nxt;
      if (!pcEn && !(&stallCount)) stallCount <= stallCount + CNT_W'(1);
    end
  end

  a_br_div : assert property (@(posedge clk) disable iff (rst) !(exBranchTaken && exDivStart));
  a_ld_div : assert property (@(posedge clk) disable iff (rst) !(exMemRead && exDivStart));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs1, idRs2, exRd;
  logic idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, exDivStart;
  logic imemReady, dmemReq, dmemReady;
  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidFlush, idexFlush, exmemFlush, memwbFlush;
  logic divBusy, divDone;
  logic [CNT_W-1:0] stallCount;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRd(exRd), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken),
    .exDivStart(exDivStart), .imemReady(imemReady), .dmemReq(dmemReq),
    .dmemReady(dmemReady), .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn),
    .exmemEn(exmemEn), .memwbEn(memwbEn), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .exmemFlush(exmemFlush), .memwbFlush(memwbFlush),
    .divBusy(divBusy), .divDone(divDone), .stallCount(stallCount)
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, imr, dreq, drdy;
    logic [4:0] en;   // pc, ifid, idex, exmem, memwb
    logic [3:0] fl;   // ifid, idex, exmem, memwb
  } vec_t;

  vec_t tbl[13];

  // {en[4:0], fl[3:0], busy, done}
  function automatic logic [10:0] outs();
    return {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
            ifidFlush, idexFlush, exmemFlush, memwbFlush, divBusy, divDone};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp);
    nvec++;
    if (stallCount !== CNT_W'(exp)) begin
      nerr++;
      $display("FAIL %s: stallCount got %0d want %0d", name, stallCount, exp);
    end
  endtask

  task automatic idle();
    idRs1 = 0; idRs2 = 0; exRd = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    exMemRead = 0; exBranchTaken = 0; exDivStart = 0;
    imemReady = 1; dmemReq = 0; dmemReady = 0;
  endtask

  // advance one edge; inputs are then driven 1ns after it, checks 3ns after it
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000};  // idle
    tbl[1]  = '{5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 5'b00011, 4'b0100};  // load-use rs1
    tbl[2]  = '{3, 7, 1, 1, 7, 1, 0, 1, 0, 0, 5'b00011, 4'b0100};  // load-use rs2
    tbl[3]  = '{0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 5'b11111, 4'b0000};  // x0 load
    tbl[4]  = '{5, 5, 0, 0, 5, 1, 0, 1, 0, 0, 5'b11111, 4'b0000};  // rs unused
    tbl[5]  = '{5, 0, 1, 0, 5, 0, 0, 1, 0, 0, 5'b11111, 4'b0000};  // not a load
    tbl[6]  = '{5, 0, 1, 0, 5, 1, 1, 1, 0, 0, 5'b11111, 4'b1100};  // branch beats load-use
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 4'b1000};  // fetch wait
    tbl[8]  = '{9, 0, 1, 0, 9, 1, 0, 0, 0, 0, 5'b00011, 4'b0100};  // load-use beats imem
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b1100};  // branch beats imem
    tbl[10] = '{5, 0, 1, 0, 5, 1, 1, 0, 1, 0, 5'b00000, 4'b0000};  // dmem stall beats all
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 4'b0000};  // dmem ready
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11111, 4'b0000};  // idle again

    #3;
    chk("reset_outputs", outs(), 11'b00000_1111_00);
    chk_cnt("reset_count", 0);
    @(negedge clk); rst = 1'b0;

    // table vectors, all in RUN state
    begin
      int exp_cnt = 0;
      for (int i = 0; i < 13; i++) begin
        step();
        idRs1 = tbl[i].rs1; idRs2 = tbl[i].rs2; idUsesRs1 = tbl[i].u1;
        idUsesRs2 = tbl[i].u2; exRd = tbl[i].rd; exMemRead = tbl[i].mr;
        exBranchTaken = tbl[i].br; imemReady = tbl[i].imr;
        dmemReq = tbl[i].dreq; dmemReady = tbl[i].drdy;
        #2;
        chk($sformatf("vec%0d", i), outs(), {tbl[i].en, tbl[i].fl, 2'b00});
        if (!tbl[i].en[4]) exp_cnt++;
      end
      step(); idle();
      chk_cnt("table_stalls", exp_cnt);
    end

    // divide, no interference: 3 stalled cycles then divDone
    do_reset();
    step();
    exDivStart = 1;
    for (int c = 0; c < 3; c++) begin
      #2; chk($sformatf("div_c%0d", c), outs(), 11'b00011_0010_10);
      step();
    end
    #2; chk("div_done", outs(), 11'b11111_0000_11);
    step(); exDivStart = 0;
    #2; chk("div_after", outs(), 11'b11111_0000_00);
    chk_cnt("div_stalls", 3);

    // divide with a dmem stall in cycle 1: completion slips by one
    step(); exDivStart = 1;
    #2; chk("divm_c0", outs(), 11'b00011_0010_10);
    step(); dmemReq = 1; dmemReady = 0;
    #2; chk("divm_c1_dstall", outs(), 11'b00000_0000_10);
    step(); dmemReq = 0;
    #2; chk("divm_c2", outs(), 11'b00011_0010_10);
    step();
    #2; chk("divm_c3", outs(), 11'b00011_0010_10);
    step();
    #2; chk("divm_c4_done", outs(), 11'b11111_0000_11);
    step(); exDivStart = 0;
    #2; chk("divm_after", outs(), 11'b11111_0000_00);
    chk_cnt("divm_stalls", 7);

    // fetch wait for 3 cycles
    imemReady = 0;
    for (int c = 0; c < 3; c++) begin
      #2; chk($sformatf("fetch_c%0d", c), outs(), 11'b01111_1000_00);
      step();
    end
    imemReady = 1;
    #2; chk_cnt("fetch_stalls", 10);

    // async reset pulse mid-divide
    step(); exDivStart = 1;
    step();
    #1; rst = 1'b1; exDivStart = 0;
    #1; chk("rst_mid_div", outs(), 11'b00000_1111_00);
    chk_cnt("rst_mid_count", 0);
    rst = 1'b0;
    #1; chk("rst_release_run", outs(), 11'b11111_0000_00);
    step();
    #2; chk_cnt("rst_after_edge", 0);

    // saturation of the 4-bit stall counter
    imemReady = 0;
    for (int c = 0; c < 20; c++) step();
    imemReady = 1;
    #2; chk_cnt("saturate", 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage core pipeline. Combines decode-stage register usage, execute-stage load/branch/divide status and memory handshakes. Drives the enable and synchronous-flush inputs of the PC and of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). Sequences multi-cycle divides with an internal counter and keeps a saturating stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, total cycles a divide occupies EX (legal range 2..256)
CNT_W, 32, width of stallCount

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
idRs1  in  5  rs1 of instruction in ID
idRs2  in  5  rs2 of instruction in ID
idUsesRs1  in  1  ID instruction reads rs1
idUsesRs2  in  1  ID instruction reads rs2
exRd  in  5  destination register of instruction in EX
exMemRead  in  1  EX instruction is a load
exBranchTaken  in  1  EX resolved a taken branch/jump (PC redirect)
exDivStart  in  1  EX holds a divide/remainder instruction
imemReady  in  1  instruction fetch data valid this cycle
dmemReq  in  1  MEM stage issuing a data access
dmemReady  in  1  data memory completes access this cycle
pcEn  out  1  PC register load enable
ifidEn, idexEn, exmemEn, memwbEn  out  1 each  stage register enables
ifidFlush, idexFlush, exmemFlush, memwbFlush  out  1 each  synchronous clear at next edge; flush dominates enable
divBusy  out  1  divide sequencing in progress
divDone  out  1  final cycle of a divide (EX result valid, EX advances)
stallCount  out  CNT_W  cycles with pcEn=0 since reset

Behaviour:
- States: RUN, DIV_WAIT. Counter divCnt, width $clog2(DIV_CYCLES).
- rst high (async): state=RUN, divCnt=0, stallCount=0; outputs while rst high: all En=0, all Flush=1, divBusy=0, divDone=0.
- Outputs are combinational from state+inputs (same-cycle effect); evaluated in strict priority:
  1. dmemStall = dmemReq & !dmemReady: all En=0, all Flush=0. State and divCnt frozen. Pending branch/load-use re-evaluated when released (inputs held by frozen stages).
  2. DIV_WAIT with divCnt!=0: pcEn=ifidEn=idexEn=0, exmemEn=1, exmemFlush=1 (bubble into MEM), memwbEn=1; divBusy=1; divCnt decrements.
  3. DIV_WAIT with divCnt==0: divDone=1, divBusy=1; outputs per rules 5-8; next state RUN.
  4. RUN and exDivStart: outputs as rule 2, divBusy=1; divCnt loads DIV_CYCLES-2; next DIV_WAIT. exDivStart is ignored in DIV_WAIT.
  5. exBranchTaken: all En=1, ifidFlush=1, idexFlush=1 (two wrong-path instructions killed). Load-use and imem conditions ignored.
  6. Load-use: exMemRead & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)): pcEn=0, ifidEn=0, idexFlush=1, exmemEn=memwbEn=1. Exactly one bubble per load.
  7. !imemReady: pcEn=0, ifidFlush=1, remaining En=1 (downstream drains).
  8. Otherwise all En=1, all Flush=0.
- Divide latency: start cycle + DIV_CYCLES-2 wait cycles stalled, advance on cycle DIV_CYCLES; dmem stalls extend this 1:1.
- exBranchTaken and exDivStart together is illegal (assertion); exMemRead and exDivStart together likewise.
- stallCount: +1 each cycle pcEn=0 and rst low; saturates at all-ones.
- x0 never produces a load-use hazard.

Decomposition:
- Package pipeline_ctrl_pkg: state enum (RUN, DIV_WAIT), REG_ADDR_W=5, X0=5'd0.
- Sub-module load_use_detect: purely combinational rs/rd compare producing the hazard bit; all sequencing stays in pipeline_hazard_ctrl.

Test Plan:
- Load-use: exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 -> one cycle pcEn=0, ifidEn=0, idexFlush=1; next cycle (exMemRead=0) all En=1. Repeat with exRd=0 -> no stall.
- Branch vs load-use: exBranchTaken=1 with load-use true -> pcEn=1, ifidFlush=1, idexFlush=1, no stall.
- Divide, DIV_CYCLES=4: exDivStart at cycle 0 -> cycles 0-2 pcEn=0, exmemFlush=1, divBusy=1; cycle 3 divDone=1, all En=1; cycle 4 state RUN.
- Divide with dmem stall: dmemReq=1, dmemReady=0 during cycle 1 of a 4-cycle divide -> all En=0, divCnt frozen; divDone moves to cycle 4.
- Fetch wait: imemReady=0 for 3 cycles -> pcEn=0, ifidFlush=1 each cycle; stallCount +3.
- Async reset mid-divide: rst pulse between edges in DIV_WAIT -> immediately all En=0, all Flush=1, divBusy=0, stallCount=0; after release state RUN.
